flags_unit: RTL and testbench
=============================

# flags_unit

Producer side of the condition-flag interface. Computes ARM NZCV flags for each data-processing instruction from the ALU operands, op and result, and holds them in the architectural flag register. Writes are gated by the condition-check result of the same instruction. A one-deep shadow copy saves flags on exception entry and restores them on return. The `flags` output feeds the condition checker directly, using the same ordering {N,Z,C,V} as bits [3:0].

## Interface
- `WIDTH`, 32, datapath width in bits

- `clk` in 1: single clock, rising edge
- `reset` in 1: synchronous, active-high
- `alu_a` in WIDTH: ALU operand A
- `alu_b` in WIDTH: ALU operand B (post-shift)
- `alu_ctrl` in 2: 00 ADD, 01 SUB, 10 AND, 11 ORR
- `alu_result` in WIDTH: ALU result of the current instruction
- `flag_w` in 2: bit1 = write N,Z; bit0 = write C,V
- `cond_ex` in 1: condition-check result of the current instruction
- `save` in 1: exception entry; copy flags to shadow
- `restore` in 1: exception return; copy shadow to flags
- `flags` out 4: registered {N,Z,C,V}
- `saved_flags` out 4: registered shadow {N,Z,C,V}
- `shadow_valid` out 1: shadow holds a saved value
- `err` out 1: one-cycle pulse on an illegal save/restore request

## Operation
- Arithmetic is internal, WIDTH+1 bits wide:
  - `sum = {0,alu_a} + {0, SUB ? ~alu_b : alu_b} + SUB`
  - `C = sum[WIDTH]`. For SUB, C=1 means no borrow.
  - `V = (a[msb] == b'[msb]) & (sum[msb] != a[msb])`, where b' is the inverted B for SUB.
- `N = alu_result[WIDTH-1]`. `Z = (alu_result == 0)`. N and Z come from `alu_result`, not from `sum`.
- Write enables:
  - `we_nz = flag_w[1] & cond_ex`
  - `we_cv = flag_w[0] & cond_ex & ~alu_ctrl[1]`
  - Logical ops never modify C or V.
- Next-state priority, highest first:
  1. `reset`: flags=0000, saved_flags=0000, shadow_valid=0, err=0.
  2. `save & restore` together: illegal. Nothing changes except err=1 for one cycle.
  3. `restore`:
     - If shadow_valid=1: flags←saved_flags, shadow_valid←0. Any flag write from the same cycle is discarded.
     - If shadow_valid=0: flags unchanged, err=1.
  4. `save`:
     - If shadow_valid=0: saved_flags←current (pre-update) flags, shadow_valid←1. The normal flag write still applies this cycle.
     - If shadow_valid=1: the shadow is not overwritten and err=1. The normal flag write still applies.
  5. Normal path: update N,Z if we_nz, and C,V if we_cv. All other bits hold.
- err is 0 in every cycle not listed above.

## Timing
- All outputs are registered. There is no combinational path from any input to any output.
- Write latency is 1: the flags computed in cycle t are visible on `flags` in cycle t+1. This is exactly when the next instruction's condition check reads them.
- `saved_flags` and `shadow_valid` update at the same edge as `flags`.
- A reset asserted mid-sequence (for example, during a pending restore) wins unconditionally at that edge.
- `err` is asserted in the cycle after the offending request and is low in the following cycle unless the request repeats.
- Inputs are sampled only at the rising edge. `alu_result`, `alu_a` and `alu_b` must be stable and mutually consistent when sampled.

## Test plan
All cases use WIDTH=32.
- **Reset:** assert reset 2 cycles → flags=0000, saved_flags=0000, shadow_valid=0, err=0.
- **SUB equal operands:** SUB a=5, b=5, result=0, flag_w=11, cond_ex=1 → next cycle flags=0110 (Z=1, C=1).
- **ADD signed overflow:** ADD a=0x7FFFFFFF, b=1, result=0x80000000, flag_w=11 → flags=1001.
- **Unsigned wrap:** ADD a=0xFFFFFFFF, b=1, result=0 → flags=0110.
- **Gating and logical ops:**
  - From flags=1001, SUB 3−5 with cond_ex=0 → flags stay 1001.
  - Then AND with result=0, flag_w=11, cond_ex=1 → flags=0101 (C,V retained).
- **Shadow:**
  - From flags=0110, assert save with a concurrent SUB 1−2 (result=0xFFFFFFFF) → flags=1000, saved_flags=0110, shadow_valid=1.
  - A second save → err pulse; saved_flags stays 0110.
  - restore → flags=0110, shadow_valid=0.
  - restore again → err pulse; flags unchanged.
  - save+restore in the same cycle → err pulse; no state change.

Source files
------------

// File: rtl/flags_unit.sv
// rtl/flags_unit.sv - ARM NZCV flag producer with architectural flag register and one-deep shadow
module flags_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] alu_a,
    input  logic [WIDTH-1:0] alu_b,
    input  logic [1:0]       alu_ctrl,
    input  logic [WIDTH-1:0] alu_result,
    input  logic [1:0]       flag_w,
    input  logic             cond_ex,
    input  logic             save,
    input  logic             restore,
    output logic [3:0]       flags,
    output logic [3:0]       saved_flags,
    output logic             shadow_valid,
    output logic             err
);

    localparam logic [1:0] OP_SUB = 2'b01;

    logic             is_sub;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum;
    logic             flag_n;
    logic             flag_z;
    logic             flag_c;
    logic             flag_v;
    logic             we_nz;
    logic             we_cv;
    logic [3:0]       next_flags;

    // Subtraction is a + ~b + 1, so carry-out of 1 means no borrow.
    assign is_sub = (alu_ctrl == OP_SUB);
    assign b_eff  = is_sub ? ~alu_b : alu_b;
    assign sum    = {1'b0, alu_a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};

    assign flag_c = sum[WIDTH];
    assign flag_v = (alu_a[WIDTH-1] == b_eff[WIDTH-1]) & (sum[WIDTH-1] != alu_a[WIDTH-1]);
    assign flag_n = alu_result[WIDTH-1];
    assign flag_z = (alu_result == '0);

    // Logical ops (alu_ctrl[1] set) never touch C or V.
    assign we_nz = flag_w[1] & cond_ex;
    assign we_cv = flag_w[0] & cond_ex & ~alu_ctrl[1];

    always_comb begin
        next_flags = flags;
        if (we_nz) begin
            next_flags[3:2] = {flag_n, flag_z};
        end
        if (we_cv) begin
            next_flags[1:0] = {flag_c, flag_v};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            flags        <= 4'b0000;
            saved_flags  <= 4'b0000;
            shadow_valid <= 1'b0;
            err          <= 1'b0;
        end else begin
            err <= 1'b0;
            if (save && restore) begin
                err <= 1'b1;
            end else if (restore) begin
                // A restore discards any flag write issued in the same cycle.
                if (shadow_valid) begin
                    flags        <= saved_flags;
                    shadow_valid <= 1'b0;
                end else begin
                    err <= 1'b1;
                end
            end else begin
                if (save) begin
                    if (!shadow_valid) begin
                        saved_flags  <= flags;
                        shadow_valid <= 1'b1;
                    end else begin
                        err <= 1'b1;
                    end
                end
                flags <= next_flags;
            end
        end
    end

endmodule

// File: tb/tb_flags_unit.sv
// tb/tb_flags_unit.sv - self-checking bench for flags_unit with a behavioural reference model
module tb_flags_unit;

    logic        clk;
    logic        reset;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [1:0]  alu_ctrl;
    logic [31:0] alu_result;
    logic [1:0]  flag_w;
    logic        cond_ex;
    logic        save;
    logic        restore;
    logic [3:0]  flags;
    logic [3:0]  saved_flags;
    logic        shadow_valid;
    logic        err;

    int checks;
    int errors;

    logic [3:0] m_flags;
    logic [3:0] m_saved;
    logic       m_valid;
    logic       m_err;

    flags_unit #(.WIDTH(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_ctrl     (alu_ctrl),
        .alu_result   (alu_result),
        .flag_w       (flag_w),
        .cond_ex      (cond_ex),
        .save         (save),
        .restore      (restore),
        .flags        (flags),
        .saved_flags  (saved_flags),
        .shadow_valid (shadow_valid),
        .err          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Flags from plain integer arithmetic: C from unsigned range, V from signed range.
    function automatic logic [3:0] ref_nzcv(input logic [31:0] a, input logic [31:0] b,
                                            input logic [1:0] ctrl, input logic [31:0] res);
        longint ua, ub, sa, sb, ss;
        logic c, v;
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (ctrl == 2'b01) begin
            c  = (ua >= ub);
            ss = sa - sb;
        end else begin
            c  = ((ua + ub) > 64'sh0000_0000_FFFF_FFFF);
            ss = sa + sb;
        end
        v = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
        return {res[31], (res == 32'd0), c, v};
    endfunction

    function automatic logic [31:0] true_result(input logic [31:0] a, input logic [31:0] b,
                                                input logic [1:0] ctrl);
        case (ctrl)
            2'b00:   return a + b;
            2'b01:   return a - b;
            2'b10:   return a & b;
            default: return a | b;
        endcase
    endfunction

    task automatic model_step(input logic [31:0] a, input logic [31:0] b, input logic [1:0] ctrl,
                              input logic [31:0] res, input logic [1:0] fw, input logic ce,
                              input logic sv, input logic rs, input logic rst);
        logic [3:0] calc;
        logic [3:0] nxt;
        calc = ref_nzcv(a, b, ctrl, res);
        nxt  = m_flags;
        if (fw[1] && ce) nxt[3:2] = calc[3:2];
        if (fw[0] && ce && (ctrl == 2'b00 || ctrl == 2'b01)) nxt[1:0] = calc[1:0];
        m_err = 1'b0;
        if (rst) begin
            m_flags = 4'b0000;
            m_saved = 4'b0000;
            m_valid = 1'b0;
        end else if (sv && rs) begin
            m_err = 1'b1;
        end else if (rs) begin
            if (m_valid) begin
                m_flags = m_saved;
                m_valid = 1'b0;
            end else begin
                m_err = 1'b1;
            end
        end else begin
            if (sv) begin
                if (!m_valid) begin
                    m_saved = m_flags;
                    m_valid = 1'b1;
                end else begin
                    m_err = 1'b1;
                end
            end
            m_flags = nxt;
        end
    endtask

    task automatic apply(input logic [31:0] a, input logic [31:0] b, input logic [1:0] ctrl,
                         input logic [31:0] res, input logic [1:0] fw, input logic ce,
                         input logic sv, input logic rs, input logic rst);
        alu_a      = a;
        alu_b      = b;
        alu_ctrl   = ctrl;
        alu_result = res;
        flag_w     = fw;
        cond_ex    = ce;
        save       = sv;
        restore    = rs;
        reset      = rst;
        model_step(a, b, ctrl, res, fw, ce, sv, rs, rst);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        apply(32'd0, 32'd0, 2'b00, 32'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        apply(32'd0, 32'd0, 2'b00, 32'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
        apply(32'd0, 32'd0, 2'b00, 32'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if ({flags, saved_flags, shadow_valid, err} !== 10'b0) begin
            errors++;
            $display("FAIL reset: flags=%b saved=%b valid=%b err=%b, required all zero",
                     flags, saved_flags, shadow_valid, err);
        end
    endtask

    task automatic test_arith();
        apply(32'd5, 32'd5, 2'b01, 32'd0, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (flags !== 4'b0110) begin
            errors++;
            $display("FAIL sub_equal: flags=%b required 0110", flags);
        end
        apply(32'hFFFF_FFFF, 32'd1, 2'b00, 32'd0, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (flags !== 4'b0110) begin
            errors++;
            $display("FAIL unsigned_wrap: flags=%b required 0110", flags);
        end
        apply(32'h7FFF_FFFF, 32'd1, 2'b00, 32'h8000_0000, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (flags !== 4'b1001) begin
            errors++;
            $display("FAIL add_overflow: flags=%b required 1001", flags);
        end
    endtask

    task automatic test_gating();
        apply(32'd3, 32'd5, 2'b01, 32'hFFFF_FFFE, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (flags !== 4'b1001) begin
            errors++;
            $display("FAIL cond_gated: flags=%b required 1001", flags);
        end
        apply(32'hF0, 32'h0F, 2'b10, 32'd0, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (flags !== 4'b0101) begin
            errors++;
            $display("FAIL logical_keeps_cv: flags=%b required 0101", flags);
        end
        apply(32'd2, 32'd3, 2'b01, 32'hFFFF_FFFF, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (flags !== 4'b0100) begin
            errors++;
            $display("FAIL cv_only_write: flags=%b required 0100", flags);
        end
    endtask

    task automatic test_shadow();
        apply(32'd5, 32'd5, 2'b01, 32'd0, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0);
        apply(32'd1, 32'd2, 2'b01, 32'hFFFF_FFFF, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0);
        checks++;
        if (flags !== 4'b1000 || saved_flags !== 4'b0110 || shadow_valid !== 1'b1 || err !== 1'b0) begin
            errors++;
            $display("FAIL save: flags=%b saved=%b valid=%b err=%b required 1000 0110 1 0",
                     flags, saved_flags, shadow_valid, err);
        end
        apply(32'd0, 32'd0, 2'b00, 32'd0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (err !== 1'b1 || saved_flags !== 4'b0110 || flags !== 4'b1000) begin
            errors++;
            $display("FAIL double_save: err=%b saved=%b flags=%b required 1 0110 1000",
                     err, saved_flags, flags);
        end
        idle();
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL err_one_cycle: err=%b required 0", err);
        end
        apply(32'h7FFF_FFFF, 32'd1, 2'b00, 32'h8000_0000, 2'b11, 1'b1, 1'b0, 1'b1, 1'b0);
        checks++;
        if (flags !== 4'b0110 || shadow_valid !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL restore: flags=%b valid=%b err=%b required 0110 0 0",
                     flags, shadow_valid, err);
        end
        apply(32'd0, 32'd0, 2'b00, 32'd0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (err !== 1'b1 || flags !== 4'b0110) begin
            errors++;
            $display("FAIL empty_restore: err=%b flags=%b required 1 0110", err, flags);
        end
        apply(32'd0, 32'd0, 2'b00, 32'd0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
        apply(32'h7FFF_FFFF, 32'd1, 2'b00, 32'h8000_0000, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0);
        checks++;
        if (err !== 1'b1 || flags !== 4'b0110 || saved_flags !== 4'b0110 || shadow_valid !== 1'b1) begin
            errors++;
            $display("FAIL save_and_restore: err=%b flags=%b saved=%b valid=%b required 1 0110 0110 1",
                     err, flags, saved_flags, shadow_valid);
        end
        apply(32'd0, 32'd0, 2'b00, 32'd0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
        checks++;
        if ({flags, saved_flags, shadow_valid, err} !== 10'b0) begin
            errors++;
            $display("FAIL reset_wins: flags=%b saved=%b valid=%b err=%b required all zero",
                     flags, saved_flags, shadow_valid, err);
        end
    endtask

    task automatic test_random();
        logic [31:0] edge_vals [6];
        logic [31:0] a, b, res;
        logic [1:0]  ctrl, fw;
        logic        ce, sv, rs, rst;
        edge_vals[0] = 32'h0000_0000;
        edge_vals[1] = 32'h0000_0001;
        edge_vals[2] = 32'h7FFF_FFFF;
        edge_vals[3] = 32'h8000_0000;
        edge_vals[4] = 32'hFFFF_FFFF;
        edge_vals[5] = 32'h8000_0001;
        for (int i = 0; i < 500; i++) begin
            a    = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 5)] : $urandom;
            b    = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 5)] : $urandom;
            if ($urandom_range(0, 9) == 0) b = a;
            ctrl = 2'($urandom_range(0, 3));
            res  = true_result(a, b, ctrl);
            if ($urandom_range(0, 9) == 0) res = 32'd0;
            fw   = 2'($urandom_range(0, 3));
            ce   = ($urandom_range(0, 3) != 0);
            sv   = ($urandom_range(0, 9) == 0);
            rs   = ($urandom_range(0, 9) == 0);
            rst  = ($urandom_range(0, 49) == 0);
            apply(a, b, ctrl, res, fw, ce, sv, rs, rst);
            checks++;
            if (flags !== m_flags || saved_flags !== m_saved || shadow_valid !== m_valid || err !== m_err) begin
                errors++;
                $display("FAIL random[%0d]: got flags=%b saved=%b valid=%b err=%b, required %b %b %b %b",
                         i, flags, saved_flags, shadow_valid, err, m_flags, m_saved, m_valid, m_err);
            end
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        m_flags = 4'b0000;
        m_saved = 4'b0000;
        m_valid = 1'b0;
        m_err   = 1'b0;
        test_reset();
        test_arith();
        test_gating();
        test_shadow();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
